// File: rtl/text_pkg.sv
// text_pkg: renderer FSM states, ASCII control codes and default font/screen geometry.
package text_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT, S_RELEASE, S_ADVANCE, S_WRAPCHK
   } state_t;
   localparam int CHAR_LF = 'h0A;
   localparam int CHAR_SP = 'h20;
   localparam int CHAR_BS = 'h08;
   localparam int DEF_FONT_W   = 5;
   localparam int DEF_FONT_H   = 7;
   localparam int DEF_SPACING  = 1;
   localparam int DEF_SCREEN_W = 160;
   localparam int DEF_SCREEN_H = 120;
endpackage

// File: rtl/char_fifo.sv
// char_fifo: synchronous show-ahead character FIFO; a push while full is dropped even if a pop coincides.
module char_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 7
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          push, pop;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign push    = push_i && !full_o;
   assign pop     = pop_i && !empty_o;
   assign head_o  = mem_q[rd_q];
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_q] <= data_i;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

// File: rtl/text_renderer.sv
// text_renderer: queues ASCII characters and drives the character-render handshake with cursor advance/wrap.
// Define TEXT_RENDERER_BACKSPACE_EN to make 0x08 move the cursor back one cell instead of drawing it.
module text_renderer
   import text_pkg::*;
#(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int CHAR_W   = 7,
   parameter int SIZE_W   = 3,
   parameter int FONT_W   = DEF_FONT_W,
   parameter int FONT_H   = DEF_FONT_H,
   parameter int SPACING  = DEF_SPACING,
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H,
   parameter int DEPTH    = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [CHAR_W-1:0] in_char,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [X_W-1:0]    start_x,
   input  logic [Y_W-1:0]    start_y,
   input  logic [SIZE_W-1:0] size,
   input  logic              home,
   output logic [CHAR_W-1:0] cr_char,
   output logic [X_W-1:0]    cr_origin_x,
   output logic [Y_W-1:0]    cr_origin_y,
   output logic [SIZE_W-1:0] cr_size,
   output logic              cr_enable,
   input  logic              cr_finished,
   output logic              busy
);
   // Wide enough that cursor + cell never wraps before the screen-edge compare.
   localparam int CW = (X_W > Y_W ? X_W : Y_W) + SIZE_W + 1;
   state_t            state_q;
   logic [CW-1:0]     x_q, y_q;
   logic              home_q, en_q;
   logic [CHAR_W-1:0] char_q;
   logic [X_W-1:0]    org_x_q;
   logic [Y_W-1:0]    org_y_q;
   logic [SIZE_W-1:0] size_q, eff;
   logic [CHAR_W-1:0] head;
   logic              full, empty;
   logic [CW-1:0]     sx, sy, lw, lh, cw, ch, y_w, x_n, y_n;
   logic              wrap_x;
   char_fifo #(.DEPTH(DEPTH), .W(CHAR_W)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (in_valid),
      .data_i  (in_char),
      .pop_i   (state_q == S_LOAD),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );
   assign in_ready    = !full;
   assign busy        = !empty || state_q != S_IDLE;
   assign cr_char     = char_q;
   assign cr_origin_x = org_x_q;
   assign cr_origin_y = org_y_q;
   assign cr_size     = size_q;
   assign cr_enable   = en_q;
   assign eff    = size == '0 ? SIZE_W'(1) : size;
   assign sx     = CW'(start_x);
   assign sy     = CW'(start_y);
   assign lw     = CW'(eff) * CW'(FONT_W + SPACING);
   assign lh     = CW'(eff) * CW'(FONT_H + SPACING);
   assign cw     = CW'(size_q) * CW'(FONT_W + SPACING);
   assign ch     = CW'(size_q) * CW'(FONT_H + SPACING);
   assign wrap_x = x_q + cw > CW'(SCREEN_W);
   assign x_n    = wrap_x ? sx : x_q;
   assign y_w    = wrap_x ? y_q + ch : y_q;
   assign y_n    = y_w + ch > CW'(SCREEN_H) ? sy : y_w;
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         x_q     <= sx;
         y_q     <= sy;
         home_q  <= 1'b0;
         en_q    <= 1'b0;
         char_q  <= '0;
         org_x_q <= '0;
         org_y_q <= '0;
         size_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (home || home_q) begin
                  x_q    <= sx;
                  y_q    <= sy;
                  home_q <= 1'b0;
               end
               if (!empty) state_q <= S_LOAD;
            end
            S_LOAD: begin
               size_q <= eff;
               if (head == CHAR_W'(CHAR_LF)) begin
                  x_q     <= sx;
                  y_q     <= y_q + lh;
                  state_q <= S_WRAPCHK;
               end else if (head == CHAR_W'(CHAR_SP)) begin
                  state_q <= S_ADVANCE;
`ifdef TEXT_RENDERER_BACKSPACE_EN
               end else if (head == CHAR_W'(CHAR_BS)) begin
                  if (x_q >= sx + lw) x_q <= x_q - lw;
                  state_q <= S_IDLE;
`endif
               end else begin
                  char_q  <= head;
                  org_x_q <= X_W'(x_q);
                  org_y_q <= Y_W'(y_q);
                  state_q <= S_START;
               end
            end
            S_START: begin
               en_q    <= 1'b1;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (cr_finished) begin
                  en_q    <= 1'b0;
                  state_q <= S_RELEASE;
               end
            end
            S_RELEASE: state_q <= cr_finished ? S_RELEASE : S_ADVANCE;
            S_ADVANCE: begin
               x_q     <= x_q + cw;
               state_q <= S_WRAPCHK;
            end
            S_WRAPCHK: begin
               x_q     <= (home || home_q) ? sx : x_n;
               y_q     <= (home || home_q) ? sy : y_n;
               home_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
         if (home && state_q != S_IDLE && state_q != S_WRAPCHK) home_q <= 1'b1;
      end
   end
endmodule
